// File: rtl/accel_rf_driver.sv
// accel_rf_driver
// ---------------
// Drives a small accelerator through its register-file port. A transaction
// latches five operands when it starts. It writes them to addresses 0..4.
// It then idles for WAIT_CYCLES cycles while the accelerator pipeline drains.
// After that it reads the two result words at addresses 5 and 6 and pulses
// o_done.
//
// Ports
//   i_clk                      single clock, all logic on the rising edge
//   i_reset                    synchronous, active-low reset
//   i_start                    start request, only honoured while idle
//   i_a, i_b, i_k, i_x, i_c    operands (N bits each)
//   o_addr                     register-file address (all ones when idle)
//   o_data                     register-file write data
//   o_RF_WE                    register-file write enable
//   i_rd_data                  read data, valid one cycle after o_addr
//   o_busy                     high whenever a transaction is in flight
//   o_done                     one-cycle pulse when o_res_lo/o_res_hi are fresh
//   o_res_lo, o_res_hi         captured words from addresses 5 and 6
//
// Every output is a register. The combinational block below works out
// next-state values, and those values are loaded into the output registers.
// As a result, the outputs always describe the state that the FSM is
// currently in.

module accel_rf_driver #(
    parameter int N              = 32,
    parameter int RF_Addr_BITNES = 3,
    parameter int WAIT_CYCLES    = 6    // legal range 1..255
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [N-1:0]              i_a,
    input  logic [N-1:0]              i_b,
    input  logic [N-1:0]              i_k,
    input  logic [N-1:0]              i_x,
    input  logic [N-1:0]              i_c,
    output logic [RF_Addr_BITNES-1:0] o_addr,
    output logic [N-1:0]              o_data,
    output logic                      o_RF_WE,
    input  logic [N-1:0]              i_rd_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [N-1:0]              o_res_lo,
    output logic [N-1:0]              o_res_hi
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RD_LO = 3'd3;
    localparam logic [2:0] S_RD_HI = 3'd4;
    localparam logic [2:0] S_CAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int                        NUM_OPS       = 5;
    localparam logic [2:0]                LAST_WR_IDX   = 3'd4;
    localparam logic [7:0]                WAIT_CNT_INIT = 8'(WAIT_CYCLES);
    localparam logic [RF_Addr_BITNES-1:0] ADDR_IDLE     = '1;
    localparam logic [RF_Addr_BITNES-1:0] ADDR_RES_LO   = RF_Addr_BITNES'(5);
    localparam logic [RF_Addr_BITNES-1:0] ADDR_RES_HI   = RF_Addr_BITNES'(6);

    logic [2:0] state_reg, state_next;
    logic [2:0] wr_idx_reg, wr_idx_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;

    logic [RF_Addr_BITNES-1:0] addr_next;
    logic [N-1:0]              data_next;
    logic                      we_next;

    logic [N-1:0] op_in  [NUM_OPS];
    logic [N-1:0] op_reg [NUM_OPS];

    // The operand order here matches the write order to addresses 0..4.
    assign op_in[0] = i_a;
    assign op_in[1] = i_b;
    assign op_in[2] = i_k;
    assign op_in[3] = i_x;
    assign op_in[4] = i_c;

    logic start_accept;
    assign start_accept = (state_reg == S_IDLE) && i_start;

    // Operands are latched only when a start is accepted. While busy, the
    // operand inputs may change freely.
    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_latch
            always_ff @(posedge i_clk) begin
                if (!i_reset) begin
                    op_reg[gi] <= '0;
                end else if (start_accept) begin
                    op_reg[gi] <= op_in[gi];
                end
            end
        end
    endgenerate

    // Next-state logic.
    always_comb begin
        state_next    = state_reg;
        wr_idx_next   = wr_idx_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    state_next  = S_WR;
                    wr_idx_next = 3'd0;
                end
            end
            S_WR: begin
                if (wr_idx_reg == LAST_WR_IDX) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = WAIT_CNT_INIT;
                end else begin
                    wr_idx_next = wr_idx_reg + 3'd1;
                end
            end
            S_WAIT: begin
                // The counter is loaded with WAIT_CYCLES on entry, so the
                // FSM spends exactly that many cycles in this state.
                if (wait_cnt_reg <= 8'd1) begin
                    state_next = S_RD_LO;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 8'd1;
                end
            end
            S_RD_LO: state_next = S_RD_HI;
            S_RD_HI: state_next = S_CAP;
            S_CAP:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus values for the state being entered. On the IDLE->WR edge the
    // operand registers are still loading, so the first word is taken
    // straight from the inputs.
    always_comb begin
        addr_next = ADDR_IDLE;
        data_next = '0;
        we_next   = 1'b0;
        case (state_next)
            S_WR: begin
                we_next   = 1'b1;
                addr_next = RF_Addr_BITNES'(wr_idx_next);
                data_next = (state_reg == S_IDLE) ? op_in[wr_idx_next]
                                                  : op_reg[wr_idx_next];
            end
            S_RD_LO: addr_next = ADDR_RES_LO;
            S_RD_HI: addr_next = ADDR_RES_HI;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_reg    <= S_IDLE;
            wr_idx_reg   <= 3'd0;
            wait_cnt_reg <= 8'd0;
            o_addr       <= ADDR_IDLE;
            o_data       <= '0;
            o_RF_WE      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_res_lo     <= '0;
            o_res_hi     <= '0;
        end else begin
            state_reg    <= state_next;
            wr_idx_reg   <= wr_idx_next;
            wait_cnt_reg <= wait_cnt_next;
            o_addr       <= addr_next;
            o_data       <= data_next;
            o_RF_WE      <= we_next;
            o_busy       <= (state_next != S_IDLE);
            o_done       <= (state_next == S_DONE);
            // Read data trails the address by one cycle. Address 5 is
            // presented in RD_LO, so its data arrives during RD_HI. Address 6
            // is presented in RD_HI, so its data arrives during CAP.
            if (state_reg == S_RD_HI) begin
                o_res_lo <= i_rd_data;
            end
            if (state_reg == S_CAP) begin
                o_res_hi <= i_rd_data;
            end
        end
    end

endmodule
